// File: rtl/usb_tx_pkt_pkg.sv
// Shared USB definitions: PID codes, the PID byte helper and the framer's state encoding.
package usb_tx_pkt_pkg;

    localparam int MAX_LEN_DEF = 64;

    // Token, data and handshake PIDs (low nibble); also used by the receive side.
    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_PAYLOAD,
        ST_DRAIN,
        ST_WAIT_EOP
    } tx_state_t;

    function automatic logic [7:0] pid_byte(input logic [3:0] p);
        return {~p, p};
    endfunction

endpackage

// File: rtl/usb_tx_prefetch.sv
// One-byte payload holding register with fetch counter; also discards bytes while draining.
module usb_tx_prefetch #(
    parameter int LEN_W = 7
) (
    input  logic             clk_48,
    input  logic             rst_n,
    input  logic             start,
    input  logic             fetch_en,
    input  logic             drain_en,
    input  logic             take,
    input  logic [LEN_W-1:0] len,
    input  logic             pl_valid,
    input  logic [7:0]       pl_data,
    output logic             pl_ready,
    output logic             hold_full,
    output logic [7:0]       hold_data,
    output logic             all_fetched
);

    logic [LEN_W-1:0] fetched;
    logic             xfer;

    assign all_fetched = (fetched == len);
    // Derived from registered state only, so upstream may wait on it before raising pl_valid.
    assign pl_ready    = !all_fetched && ((fetch_en && !hold_full) || drain_en);
    assign xfer        = pl_ready && pl_valid;

    // An emptied hold reads as 8'h00, which is what the transmitter latches on underrun.
    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            fetched   <= '0;
            hold_full <= 1'b0;
            hold_data <= 8'h00;
        end else if (start) begin
            fetched   <= '0;
            hold_full <= 1'b0;
            hold_data <= 8'h00;
        end else begin
            if (xfer)
                fetched <= fetched + LEN_W'(1);
            if (xfer && fetch_en) begin
                hold_full <= 1'b1;
                hold_data <= pl_data;
            end else if (take) begin
                hold_full <= 1'b0;
                hold_data <= 8'h00;
            end
        end
    end

endmodule

// File: rtl/usb_tx_pkt.sv
// Packet framer feeding the USB bit-level transmitter: PID byte, payload stream, CRC16 request.
module usb_tx_pkt
    import usb_tx_pkt_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = 7
) (
    input  logic             clk_48,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_pid,
    input  logic             cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             pl_valid,
    output logic             pl_ready,
    input  logic [7:0]       pl_data,
    output logic             transmit,
    output logic [7:0]       data,
    output logic             update_crc16,
    output logic             send_crc16,
    input  logic             data_strobe,
    input  logic             usb_tx_en,
    output logic             busy,
    output logic             done,
    output logic             err_underrun,
    output logic             err_len
);

    tx_state_t        state, state_nxt;
    logic             ready_en;
    logic [3:0]       pid_r;
    logic             flag_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] sent;
    logic             eop_seen;

    logic             accept, bad_len, take, underrun, finish_tx, eop_hit;
    logic             hold_full, all_fetched;
    logic [7:0]       hold_data;

    usb_tx_prefetch #(.LEN_W(LEN_W)) u_prefetch (
        .clk_48      (clk_48),
        .rst_n       (rst_n),
        .start       (accept),
        .fetch_en    (state == ST_PID || state == ST_PAYLOAD),
        .drain_en    (state == ST_DRAIN),
        .take        (take),
        .len         (len_r),
        .pl_valid    (pl_valid),
        .pl_data     (pl_data),
        .pl_ready    (pl_ready),
        .hold_full   (hold_full),
        .hold_data   (hold_data),
        .all_fetched (all_fetched)
    );

    // ready_en keeps cmd_ready low while reset is held.
    assign cmd_ready    = ready_en && (state == ST_IDLE) && !usb_tx_en;
    assign busy         = (state != ST_IDLE);
    assign update_crc16 = (state == ST_PAYLOAD);
    assign data         = (state == ST_PID)     ? pid_byte(pid_r) :
                          (state == ST_PAYLOAD) ? hold_data       : 8'h00;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        bad_len   = 1'b0;
        take      = 1'b0;
        underrun  = 1'b0;
        finish_tx = 1'b0;
        eop_hit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_data && (cmd_len > LEN_W'(MAX_LEN))) begin
                        bad_len = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = ST_PID;
                    end
                end
            end
            ST_PID: begin
                if (data_strobe) begin
                    if (flag_r && (len_r != '0)) begin
                        state_nxt = ST_PAYLOAD;
                    end else begin
                        finish_tx = 1'b1;
                        state_nxt = ST_WAIT_EOP;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (data_strobe) begin
                    if (hold_full) begin
                        take = 1'b1;
                        if (sent + LEN_W'(1) == len_r) begin
                            finish_tx = 1'b1;
                            state_nxt = ST_WAIT_EOP;
                        end
                    end else begin
                        underrun  = 1'b1;
                        state_nxt = all_fetched ? ST_WAIT_EOP : ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (all_fetched)
                    state_nxt = ST_WAIT_EOP;
            end
            ST_WAIT_EOP: begin
                if (!usb_tx_en || eop_seen) begin
                    eop_hit   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            ready_en     <= 1'b0;
            flag_r       <= 1'b0;
            len_r        <= '0;
            sent         <= '0;
            eop_seen     <= 1'b0;
            transmit     <= 1'b0;
            send_crc16   <= 1'b0;
            done         <= 1'b0;
            err_underrun <= 1'b0;
            err_len      <= 1'b0;
        end else begin
            state        <= state_nxt;
            ready_en     <= 1'b1;
            done         <= eop_hit;
            err_len      <= bad_len;
            err_underrun <= underrun;
            if (accept) begin
                flag_r     <= cmd_data;
                len_r      <= cmd_data ? cmd_len : '0;
                sent       <= '0;
                eop_seen   <= 1'b0;
                transmit   <= 1'b1;
                send_crc16 <= cmd_data;
            end
            if (take)
                sent <= sent + LEN_W'(1);
            if (finish_tx)
                transmit <= 1'b0;
            if (underrun) begin
                transmit   <= 1'b0;
                send_crc16 <= 1'b0;
            end
            if (eop_hit)
                send_crc16 <= 1'b0;
            // The bus may be released while the upstream is still being drained.
            if (state == ST_DRAIN && !usb_tx_en)
                eop_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk_48) begin
        if (accept)
            pid_r <= cmd_pid;
    end

endmodule
